evt_ingress_buffer: RTL

- Upstream stage of the LSTM security top-level FSM.
- Collects monitored events (syscall or branch) arriving as 4 x 64-bit beats per event and reassembles each into a 256-bit record tagged with type and PID.
- Queues records in a small FIFO.
- Presents one record at a time to the top FSM through the `oBuff_on` / `iTop_ready` handshake.

---
 rtl/evt_ingress_buffer_pkg.sv | 16 +
 rtl/evt_ingress_buffer_fifo.sv | 55 +++++
 rtl/evt_ingress_buffer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/evt_ingress_buffer_pkg.sv
// Shared constants for the event ingress path and the security top-level FSM.
package evt_ingress_buffer_pkg;

    localparam logic SYS_TYPE = 1'b0;
    localparam logic BR_TYPE  = 1'b1;

    localparam int unsigned EVT_W  = 256;
    localparam int unsigned BEAT_W = 64;
    localparam int unsigned BEATS  = 4;

    typedef enum logic {
        A_IDLE    = 1'b0,
        A_COLLECT = 1'b1
    } asm_state_t;

endpackage

// File: rtl/evt_ingress_buffer_fifo.sv
// Synchronous record FIFO; the head is copied into a read-out register on pop.
module evt_fifo #(
    parameter  int unsigned WIDTH = 267,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/evt_ingress_buffer.sv
// Reassembles 4-beat monitored events into tagged 256-bit records and hands
// them one at a time to the top FSM.
module evt_ingress_buffer
    import evt_ingress_buffer_pkg::*;
#(
    parameter  int unsigned PID_bit = 10,
    parameter  int unsigned DEPTH   = 8,
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               iEvt_valid,
    input  logic               iEvt_sop,
    input  logic               iEvt_type,
    input  logic [PID_bit-1:0] iEvt_PID,
    input  logic [BEAT_W-1:0]  iEvt_data,
    output logic               oEvt_ready,
    input  logic               iTop_ready,
    output logic               oBuff_on,
    output logic [EVT_W-1:0]   oBuff_data,
    output logic               oBuff_type,
    output logic [PID_bit-1:0] oBuff_PID,
    output logic [CNT_W-1:0]   oCount,
    output logic [7:0]         oDrop_cnt
);

    localparam int unsigned REC_W = 1 + PID_bit + EVT_W;

    asm_state_t                state;
    asm_state_t                state_next;
    logic [1:0]                idx;
    logic [EVT_W-BEAT_W-1:0]   partial;
    logic                      rec_type;
    logic [PID_bit-1:0]        rec_pid;
    logic                      beat;
    logic                      push;
    logic                      drop;
    logic                      pop;
    logic                      full;
    logic                      empty;
    logic [REC_W-1:0]          push_data;
    logic [REC_W-1:0]          rd_data;

    assign oEvt_ready = ~full;
    assign beat       = iEvt_valid & oEvt_ready;
    assign push_data  = {rec_type, rec_pid, partial, iEvt_data};
    assign pop        = ~oBuff_on & iTop_ready & ~empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= A_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (beat) begin
            case (state)
                A_IDLE:    if (iEvt_sop) state_next = A_COLLECT;
                A_COLLECT: if (!iEvt_sop && idx == 2'(BEATS - 1)) state_next = A_IDLE;
                default:   state_next = A_IDLE;
            endcase
        end
    end

    always_comb begin
        push = 1'b0;
        drop = 1'b0;
        case (state)
            A_IDLE:    drop = beat & ~iEvt_sop;
            A_COLLECT: begin
                drop = beat & iEvt_sop;
                push = beat & ~iEvt_sop & (idx == 2'(BEATS - 1));
            end
            default: ;
        endcase
    end

    // The last beat is never registered: it goes straight into the FIFO with the
    // three buffered beats, so idx wraps 3 -> 0 on the push edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx       <= '0;
            partial   <= '0;
            rec_type  <= SYS_TYPE;
            rec_pid   <= '0;
            oDrop_cnt <= '0;
        end else begin
            if (beat) begin
                if (iEvt_sop) begin
                    rec_type                          <= iEvt_type;
                    rec_pid                           <= iEvt_PID;
                    partial[EVT_W-BEAT_W-1 -: BEAT_W] <= iEvt_data;
                    idx                               <= 2'd1;
                end else if (state == A_COLLECT) begin
                    case (idx)
                        2'd1:    partial[2*BEAT_W-1 -: BEAT_W] <= iEvt_data;
                        2'd2:    partial[BEAT_W-1:0]           <= iEvt_data;
                        default: ;
                    endcase
                    idx <= idx + 1'b1;
                end
            end
            if (drop && oDrop_cnt != 8'hFF) oDrop_cnt <= oDrop_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) oBuff_on <= 1'b0;
        else         oBuff_on <= pop;
    end

    evt_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .rd_data   (rd_data),
        .full      (full),
        .empty     (empty),
        .count     (oCount)
    );

    assign {oBuff_type, oBuff_PID, oBuff_data} = rd_data;

endmodule
